accel_sequencer: RTL
====================

Name: accel_sequencer

Overview:
FPGA-side controller that runs one complete accelerator job. It pulses the accelerator's start, waits for done with a timeout, then issues NUM_RESULTS read strobes. Each 18-bit result is captured and streamed to a downstream consumer (display or UART) over a valid/ready handshake. It sits between the board push-button/top-level logic and the Accelerator's start/read/done/out interface.

Parameters:
DATA_W, 18, width of accelerator result bus
NUM_RESULTS, 8, number of read strobes/results per job
READ_HOLD, 3, cycles acc_read is held high per strobe (≥1)
READ_GAP, 3, cycles acc_read is held low after each strobe (≥1)
TIMEOUT, 4096, max cycles in WAIT_DONE before error (≥2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
go  in  1  job request, level; internally rising-edge detected
acc_start  out  1  start strobe to accelerator
acc_done  in  1  accelerator done (level)
acc_read  out  1  read strobe to accelerator
acc_out  in  DATA_W  accelerator result bus
res_data  out  DATA_W  captured result
res_valid  out  1  res_data valid
res_ready  in  1  consumer accepts when res_valid&res_ready
res_last  out  1  high with final result of a job
busy  out  1  high in any state except IDLE
job_done  out  1  one-cycle pulse when job finishes normally
err  out  1  sticky timeout flag; cleared on next accepted go

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters, index and go-edge register cleared. Reset mid-job aborts immediately; acc_start/acc_read drop without waiting for clk.
- go edge = go & ~go_q, registered. Edges outside IDLE are ignored (not queued).
- IDLE: on go edge -> START; clear err.
- START: acc_start=1 for exactly one cycle -> WAIT_DONE; clear wait counter.
- WAIT_DONE: acc_done sampled each cycle. If high -> SLOT with idx=0. Else increment counter; if counter==TIMEOUT-1 -> set err, -> IDLE, no job_done. acc_done high on the timeout cycle wins.
- SLOT: wait until output register is free (res_valid==0, or res_valid&res_ready this cycle) -> READ_HI.
- READ_HI: acc_read=1 for READ_HOLD cycles. On the last hold cycle, acc_out is registered into res_data; res_valid=1 the next cycle; res_last=(idx==NUM_RESULTS-1). -> READ_LO.
- READ_LO: acc_read=0 for READ_GAP cycles. Then, if idx==NUM_RESULTS-1 -> FINISH; else idx++ and -> SLOT.
- FINISH: job_done=1 for one cycle -> IDLE. The last result may still be pending in res_data; it stays valid until accepted, even in IDLE.
- Output register: res_valid clears on a handshake unless a capture happens in the same cycle. That cannot occur, because SLOT guarantees the register is free. res_data and res_last are stable while res_valid&~res_ready.
- acc_start and acc_read are never high together. acc_read is 0 outside READ_HI.
- busy is combinational from state (registered state): 0 only in IDLE.
- Counters are sized $clog2 of the max of their limits. idx is $clog2(NUM_RESULTS) bits, with a 1-bit minimum.
- Per-strobe minimum period is READ_HOLD+READ_GAP(+1 SLOT) cycles. Backpressure only extends SLOT.

Decomposition:
- Shared package: state encoding enum (IDLE, START, WAIT_DONE, SLOT, READ_HI, READ_LO, FINISH) and the default width constant DATA_W=18, shared with the Accelerator top.
- Sub-module: result_reg, a one-entry valid/ready holding register with data, last, capture input and free output. Everything else stays in the sequencer.

Test Plan:
- Normal job: go edge; model asserts done 50 cycles after start and returns 0x00011*(k+1) on read k -> 8 results 0x00011..0x00088 in order. res_last only on 0x00088; one-cycle start; job_done once; err=0.
- Strobe timing, res_ready tied 1: each acc_read high exactly 3 cycles, low exactly 3 cycles plus 1 SLOT cycle; acc_start never overlaps acc_read.
- Backpressure: res_ready low for 20 cycles after the first result -> no further acc_read until the handshake; res_data held at 0x00011; all 8 results eventually delivered, none lost or duplicated.
- Timeout (TIMEOUT=16 override): done never asserted -> err=1 on cycle 16 of WAIT_DONE; busy=0; no acc_read. Next go clears err and runs a normal job.
- go held high / re-pulsed while busy -> exactly one job runs; a go edge after job_done starts a second job.
- rst low mid-READ_HI (idx=4) -> acc_read, res_valid, busy drop asynchronously. After release, idle with err=0; a new go runs a full 8-result job.

Source files
------------

// File: rtl/accel_sequencer_pkg.sv
// Shared types and constants for the accelerator job sequencer.
// Holds the FSM state encoding and the default result width.
package accel_sequencer_pkg;

  localparam int ACC_DATA_W = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_SLOT,
    S_READ_HI,
    S_READ_LO,
    S_FINISH
  } seq_state_e;

  // Counter width for a count of n states, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accel_sequencer_if.sv
// Bundle of job request, accelerator and result-stream signals.
// master: sequencer side; slave: board/accelerator/consumer side.
interface accel_sequencer_if
  import accel_sequencer_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
);

  logic              go;
  logic              acc_start;
  logic              acc_done;
  logic              acc_read;
  logic [DATA_W-1:0] acc_out;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              res_last;
  logic              busy;
  logic              job_done;
  logic              err;

  modport master (
    input  go, acc_done, acc_out, res_ready,
    output acc_start, acc_read, res_data,
    output res_valid, res_last, busy,
    output job_done, err
  );

  modport slave (
    output go, acc_done, acc_out, res_ready,
    input  acc_start, acc_read, res_data,
    input  res_valid, res_last, busy,
    input  job_done, err
  );

endinterface

// File: rtl/accel_sequencer_result_reg.sv
// One-entry valid/ready holding register for captured results.
// Ports: capture_i/data_i/last_i load, ready_i drains, free_o = may load.
module accel_sequencer_result_reg
  import accel_sequencer_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              valid_o,
  output logic              free_o
);

  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              valid_q;

  // Free when empty or being emptied this cycle.
  assign free_o  = ~valid_q | ready_i;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      data_q  <= data_i;
      last_q  <= last_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_sequencer.sv
// Runs one accelerator job: start pulse, timed wait for done, then
// NUM_RESULTS read strobes streamed out over valid/ready. clk, rst (low).
module accel_sequencer
  import accel_sequencer_pkg::*;
#(
  parameter int DATA_W      = ACC_DATA_W,
  parameter int NUM_RESULTS = 8,
  parameter int READ_HOLD   = 3,
  parameter int READ_GAP    = 3,
  parameter int TIMEOUT     = 4096
) (
  input  logic         clk,
  input  logic         rst,
  accel_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int PMAX = (READ_HOLD > READ_GAP) ? READ_HOLD : READ_GAP;
  localparam int PW = cnt_w(PMAX);
  localparam int IW = cnt_w(NUM_RESULTS);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] H_LAST = PW'(READ_HOLD - 1);
  localparam logic [PW-1:0] G_LAST = PW'(READ_GAP - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_RESULTS - 1);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          go_q;
  logic          go_edge;
  logic          capture;
  logic          free;

  assign go_edge = bus.go & ~go_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      go_q    <= bus.go;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done on the final count still wins over the timeout
        if (bus.acc_done) begin
          idx_d   = '0;
          state_d = S_SLOT;
        end else if (cnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_SLOT: begin
        if (free) begin
          ph_d    = '0;
          state_d = S_READ_HI;
        end
      end
      S_READ_HI: begin
        if (ph_q == H_LAST) begin
          capture = 1'b1;
          ph_d    = '0;
          state_d = S_READ_LO;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_READ_LO: begin
        if (ph_q == G_LAST) begin
          ph_d = '0;
          if (idx_q == I_LAST) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SLOT;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.acc_start = (state_q == S_START);
  assign bus.acc_read  = (state_q == S_READ_HI);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.job_done  = (state_q == S_FINISH);
  assign bus.err       = err_q;

  accel_sequencer_result_reg #(
    .DATA_W (DATA_W)
  ) u_res (
    .clk       (clk),
    .rst_n     (rst),
    .capture_i (capture),
    .data_i    (bus.acc_out),
    .last_i    (idx_q == I_LAST),
    .ready_i   (bus.res_ready),
    .data_o    (bus.res_data),
    .last_o    (bus.res_last),
    .valid_o   (bus.res_valid),
    .free_o    (free)
  );

endmodule
